// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider.
// Restoring radix-2 mantissa divide, truncating, denormals flushed to zero.
module fp_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero,
  output logic            overflow,
  output logic            underflow
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, DIVIDE, NORM, DONE
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    a_q, a_d;
  logic [XLEN-1:0]    b_q, b_d;
  logic [24:0]        rem_q, rem_d;
  logic [24:0]        quo_q, quo_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic        sign;
  logic [7:0]  ea, eb;
  logic        a_zero, b_zero;
  logic        a_inf, b_inf;
  logic        a_nan, b_nan;
  logic [23:0] mb;
  logic        ge;
  logic [24:0] rem_sub;
  logic signed [9:0] bexp;
  logic [22:0] mant;

  assign sign   = a_q[31] ^ b_q[31];
  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign mb     = {1'b1, b_q[22:0]};

  assign ge      = rem_q >= {1'b0, mb};
  assign rem_sub = ge ? rem_q - {1'b0, mb} : rem_q;

  always_comb begin
    if (quo_q[24]) begin
      mant = quo_q[23:1];
      bexp = exp_q + 10'sd127;
    end else begin
      mant = quo_q[22:0];
      bexp = exp_q + 10'sd126;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        dbz_d = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        state_d = DONE;
        if (a_nan || b_nan) begin
          res_d = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
          res_d = QNAN;
        end else if (a_inf) begin
          res_d = {sign, 8'hFF, 23'd0};
        end else if (b_inf || a_zero) begin
          res_d = {sign, 31'd0};
        end else if (b_zero) begin
          res_d = {sign, 8'hFF, 23'd0};
          dbz_d = 1'b1;
        end else begin
          // Normal operands: leave result/flags alone until NORM.
          res_d   = res_q;
          dbz_d   = dbz_q;
          ovf_d   = ovf_q;
          unf_d   = unf_q;
          rem_d   = {1'b0, 1'b1, a_q[22:0]};
          quo_d   = 25'd0;
          exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb});
          cnt_d   = 5'd0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        quo_d = {quo_q[23:0], ge};
        rem_d = rem_sub << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) begin
          state_d = NORM;
        end
      end
      NORM: begin
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        state_d = DONE;
        if (bexp >= 10'sd255) begin
          res_d = {sign, 8'hFF, 23'd0};
          ovf_d = 1'b1;
        end else if (bexp <= 10'sd0) begin
          res_d = {sign, 31'd0};
          unf_d = 1'b1;
        end else begin
          res_d = {sign, bexp[7:0], mant};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign result      = res_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq.
// Hand-computed quotients, latency, hold, start-while-busy and reset.
module tb_fp_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;
  logic        overflow;
  logic        underflow;

  int vec;
  int errs;

  fp_div_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .div_by_zero(div_by_zero),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic [31:0] av,
                    input logic [31:0] bv, input logic [31:0] er,
                    input logic dz, input logic ov, input logic uf,
                    input int lat);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, {29'd0, div_by_zero, overflow, underflow},
        {29'd0, dz, ov, uf});
    @(posedge clk);
    #1;
    chk({tag, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int dn;
    int de;
    int n;
    logic [31:0] r1;
    vec   = 0;
    errs  = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    dn    = 0;
    de    = 0;
    r1    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {busy, done, div_by_zero, overflow, underflow},
        32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;

    op("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 28);
    op("-6.4/-0.5", 32'hC0CCCCCC, 32'hBF000000, 32'h414CCCCC,
       0, 0, 0, 28);
    op("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 0, 0, 28);
    repeat (3) @(posedge clk);
    #1;
    chk("hold result", result, 32'h3EAAAAAA);
    op("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 0, 2);
    op("0/0", 32'h00000000, 32'h00000000, 32'h7FC00000, 0, 0, 0, 2);
    op("-1/0", 32'hBF800000, 32'h00000000, 32'hFF800000, 1, 0, 0, 2);
    op("inf/-2", 32'h7F800000, 32'hC0000000, 32'hFF800000, 0, 0, 0, 2);
    op("1/inf", 32'h3F800000, 32'h7F800000, 32'h00000000, 0, 0, 0, 2);
    op("-0/5", 32'h80000000, 32'h40A00000, 32'h80000000, 0, 0, 0, 2);
    op("nan/1", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 0, 0, 0, 2);
    op("inf/inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 0, 0, 0, 2);
    op("denorm/2", 32'h00400000, 32'h40000000, 32'h00000000, 0, 0, 0, 2);
    op("ovf", 32'h7F000000, 32'h3E800000, 32'h7F800000, 0, 1, 0, 28);
    op("unf", 32'h00800000, 32'h7F000000, 32'h00000000, 0, 0, 1, 28);
    op("-ovf", 32'hFF000000, 32'h3E800000, 32'hFF800000, 0, 1, 0, 28);

    // start held high with operands churning during the operation
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dn++;
        de = k;
        r1 = result;
      end
      @(negedge clk);
      if (k == 28) begin
        a = 32'h3F800000;
        b = 32'h40400000;
      end else begin
        a = $urandom;
        b = $urandom;
      end
    end
    chk("held start dones", 32'(dn), 32'd1);
    chk("held start edge", 32'(de), 32'd28);
    chk("held start result", r1, 32'h40400000);
    @(posedge clk);
    #1;
    chk("held idle gap", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("held reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("held 2nd latency", 32'(n), 32'd28);
    chk("held 2nd result", result, 32'h3EAAAAAA);
    @(posedge clk);
    #1;

    // reset in DIVIDE iteration 10, after an op that left flags set
    op("ovf2", 32'h7F000000, 32'h3E800000, 32'h7F800000, 0, 1, 0, 28);
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("mid divide busy", {30'd0, busy, done}, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst mid outs", {busy, done, div_by_zero, overflow, underflow},
        32'd0);
    chk("rst mid result", result, 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst beats start", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    dn = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("no done after rst", 32'(dn), 32'd0);
    op("6/2 post rst", 32'h40C00000, 32'h40000000, 32'h40400000,
       0, 0, 0, 28);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 Parameter XLEN, default 32; operand/result width; only 32 (IEEE-754 single) is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  XLEN  dividend, IEEE-754 single.
REQ-006 b  input  XLEN  divisor, IEEE-754 single.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse; result and flags valid.
REQ-009 result  output  XLEN  quotient a/b; held until the next write.
REQ-010 div_by_zero  output  1  finite nonzero a divided by zero; valid with done, held like result.
REQ-011 overflow  output  1  exponent overflow; valid with done, held.
REQ-012 underflow  output  1  exponent underflow; valid with done, held.

Function
REQ-013 FSM states SHALL be IDLE, UNPACK, DIVIDE, NORM, DONE.
REQ-014 IDLE: start=1 on an edge latches a, b and moves to UNPACK; start=0 stays in IDLE.
REQ-015 start while busy SHALL be ignored; latched operands unchanged.
REQ-016 Operands with exponent field 0 SHALL be treated as signed zero (denormals flushed).
REQ-017 Result sign SHALL be a[31] XOR b[31] for all cases, including zero, inf and overflow/underflow; default NaN 0x7FC00000 is the only exception.
REQ-018 UNPACK special cases SHALL go straight to DONE with: NaN operand, 0/0 or inf/inf -> 0x7FC00000; a inf, b not inf -> signed inf; a finite, b inf -> signed zero; a zero, b nonzero -> signed zero; a finite nonzero, b zero -> signed inf with div_by_zero=1.
REQ-019 Otherwise UNPACK SHALL load ma={1,a[22:0]}, mb={1,b[22:0]}, remainder R=ma (25 bits), exponent E=ea-eb (10-bit signed), iteration counter 0, then enter DIVIDE.
REQ-020 DIVIDE SHALL produce one quotient bit per cycle for exactly 25 cycles, MSB first: if R>=mb, bit=1 and R=R-mb, else bit=0; then R=R<<1.
REQ-021 The 25-bit quotient q SHALL equal floor(ma*2^24/mb), in [2^23, 2^25).
REQ-022 NORM: q[24]=1 -> mantissa q[23:1], exponent E+127; q[24]=0 -> mantissa q[22:0], exponent E+126; rounding is truncation.
REQ-023 NORM: biased exponent >=255 -> signed inf (0x7F800000 | sign), overflow=1; <=0 -> signed zero, underflow=1.
REQ-024 result and all three flags SHALL be written on the edge entering DONE; flags not set by that operation SHALL be cleared on that edge.
REQ-025 DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-026 Latency, with the start-sampling edge counted as edge 1: done high after edge 28 for normal operands, after edge 2 for special cases.
REQ-027 start high in the DONE cycle SHALL be ignored; a new operation is accepted only in IDLE, so back-to-back issue needs one IDLE cycle.

Reset
REQ-028 rst=1 on an edge SHALL force IDLE, busy=0, done=0, result=0, div_by_zero=0, overflow=0, underflow=0, counter=0, from any state.
REQ-029 rst SHALL take priority over start on the same edge; an operation in flight is discarded with no done pulse.
REQ-030 After rst deasserts, the first start in IDLE SHALL run normally.

Verification
REQ-031 a=0x40C00000 (6.0), b=0x40000000 (2.0), start one cycle -> done after edge 28, result=0x40400000, all flags 0, busy high edges 1-28.
REQ-032 a=0xC0CCCCCC (-6.4), b=0xBF000000 (-0.5) -> result=0x414CCCCC (12.8); a=0x3F800000, b=0x40400000 -> result=0x3EAAAAAA (truncated 1/3).
REQ-033 a=0x3F800000, b=0x00000000 -> done after edge 2, result=0x7F800000, div_by_zero=1; a=0, b=0 -> 0x7FC00000, div_by_zero=0.
REQ-034 a=0x7F000000, b=0x3E800000 -> result=0x7F800000, overflow=1; a=0x00800000, b=0x7F000000 -> result=0x00000000, underflow=1.
REQ-035 start held high continuously with changing a/b during an operation -> operands unchanged, single done per accepted start, next accept only after an IDLE cycle.
REQ-036 rst pulsed in DIVIDE iteration 10 -> next edge IDLE, all outputs 0, no done; a following 6.0/2.0 request returns 0x40400000 with normal latency.
